// File: rtl/bcd_pkg.sv
// Shared definitions for the four-digit BCD countdown timer: controller states,
// digit limits and a preset validity helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         BCD_DIGITS = 4;

    // True when every nibble of a four-digit word is a legal BCD digit.
    function automatic logic bcd_valid(input logic [15:0] value);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (value[4*i +: 4] > BCD_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> 9 and raises borrow_out so the next
// more significant digit decrements on the same edge.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] d_in,
    input  logic       enable,
    output logic [3:0] digit,
    output logic       borrow_out
);

    always_ff @(negedge clk) begin
        if (reset) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= d_in;
        end else if (enable) begin
            digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
        end
    end

    assign borrow_out = enable && (digit == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD countdown timer: load/start/pause/tick controller driving a
// borrow chain of bcd_down_digit instances. All state changes on the falling edge.
module bcd_countdown_timer
    import bcd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        start,
    input  logic        pause,
    input  logic        tick,
    output logic [15:0] count,
    output logic        running,
    output logic        zero,
    output logic        done,
    output logic        preset_err
);

    state_t state;

    logic preset_ok;
    logic load_ok;
    logic dec;
    logic expire;
    logic borrow_0;
    logic borrow_1;
    logic borrow_2;
    logic borrow_top_unused;

    assign preset_ok = bcd_valid(preset);
    assign load_ok   = load && preset_ok;

    // A tick only counts while already in RUN and nothing of higher priority
    // (load, pause) claims the edge; start inside RUN does not block it.
    assign dec    = (state == ST_RUN) && !load && !pause && tick;
    assign expire = dec && (count == 16'h0001);

    assign zero = (count == 16'h0000);

    bcd_down_digit u_digit_0 (
        .clk        (clk),
        .reset      (reset),
        .load       (load_ok),
        .d_in       (preset[3:0]),
        .enable     (dec),
        .digit      (count[3:0]),
        .borrow_out (borrow_0)
    );

    bcd_down_digit u_digit_1 (
        .clk        (clk),
        .reset      (reset),
        .load       (load_ok),
        .d_in       (preset[7:4]),
        .enable     (borrow_0),
        .digit      (count[7:4]),
        .borrow_out (borrow_1)
    );

    bcd_down_digit u_digit_2 (
        .clk        (clk),
        .reset      (reset),
        .load       (load_ok),
        .d_in       (preset[11:8]),
        .enable     (borrow_1),
        .digit      (count[11:8]),
        .borrow_out (borrow_2)
    );

    // The chain never borrows out of the top digit: RUN is never entered at 0000.
    bcd_down_digit u_digit_3 (
        .clk        (clk),
        .reset      (reset),
        .load       (load_ok),
        .d_in       (preset[15:12]),
        .enable     (borrow_2),
        .digit      (count[15:12]),
        .borrow_out (borrow_top_unused)
    );

    always_ff @(negedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            running    <= 1'b0;
            done       <= 1'b0;
            preset_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                // An invalid preset still consumes the edge but changes nothing else.
                if (preset_ok) begin
                    state      <= ST_IDLE;
                    running    <= 1'b0;
                    preset_err <= 1'b0;
                end else begin
                    preset_err <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !zero) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            state   <= ST_HOLD;
                            running <= 1'b0;
                        end else if (expire) begin
                            state   <= ST_EXPIRED;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (start) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_EXPIRED: begin
                        state   <= ST_EXPIRED;
                        running <= 1'b0;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: integer-valued reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_bcd_countdown_timer;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] preset;
    logic        start;
    logic        pause;
    logic        tick;
    logic [15:0] count;
    logic        running;
    logic        zero;
    logic        done;
    logic        preset_err;

    int total;
    int bad;
    bit chk_en;

    // Model: decimal value plus a symbolic mode
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_EXP  = 3;

    int m_val;
    int m_mode;
    bit m_done;
    bit m_err;

    bcd_countdown_timer dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .preset     (preset),
        .start      (start),
        .pause      (pause),
        .tick       (tick),
        .count      (count),
        .running    (running),
        .zero       (zero),
        .done       (done),
        .preset_err (preset_err)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic bit preset_legal(input logic [15:0] p);
        return (p[15:12] < 10) && (p[11:8] < 10) && (p[7:4] < 10) && (p[3:0] < 10);
    endfunction

    function automatic int from_bcd(input logic [15:0] p);
        return p[15:12] * 1000 + p[11:8] * 100 + p[7:4] * 10 + p[3:0];
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            m_val  <= 0;
            m_mode <= M_IDLE;
            m_done <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (load) begin
                if (preset_legal(preset)) begin
                    m_val  <= from_bcd(preset);
                    m_mode <= M_IDLE;
                    m_err  <= 1'b0;
                end else begin
                    m_err <= 1'b1;
                end
            end else if (m_mode == M_RUN) begin
                if (pause) begin
                    m_mode <= M_HOLD;
                end else if (tick) begin
                    m_val <= m_val - 1;
                    if (m_val == 1) begin
                        m_mode <= M_EXP;
                        m_done <= 1'b1;
                    end
                end
            end else if (m_mode == M_IDLE && start && m_val != 0) begin
                m_mode <= M_RUN;
            end else if (m_mode == M_HOLD && start) begin
                m_mode <= M_RUN;
            end
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            total += 5;
            if (count !== to_bcd(m_val)) begin
                bad++;
                $display("FAIL model_count t=%0t got=%h want=%h", $time, count, to_bcd(m_val));
            end
            if (running !== (m_mode == M_RUN)) begin
                bad++;
                $display("FAIL model_running t=%0t got=%b want=%b", $time, running, m_mode == M_RUN);
            end
            if (zero !== (m_val == 0)) begin
                bad++;
                $display("FAIL model_zero t=%0t got=%b want=%b", $time, zero, m_val == 0);
            end
            if (done !== m_done) begin
                bad++;
                $display("FAIL model_done t=%0t got=%b want=%b", $time, done, m_done);
            end
            if (preset_err !== m_err) begin
                bad++;
                $display("FAIL model_err t=%0t got=%b want=%b", $time, preset_err, m_err);
            end
        end
    end

    // Inputs change 2 time units after a falling edge and hold through the next one.
    task automatic drive(input logic r, input logic l, input logic [15:0] p,
                         input logic s, input logic pa, input logic t);
        reset  = r;
        load   = l;
        preset = p;
        start  = s;
        pause  = pa;
        tick   = t;
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        chk_en = 1'b0;
        reset  = 1'b1;
        load   = 1'b0;
        preset = 16'h0000;
        start  = 1'b0;
        pause  = 1'b0;
        tick   = 1'b0;
        @(negedge clk);
        #2;
        drive(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
        chk_en = 1'b1;
        expect_val("reset_count", count, 16'h0000);
        expect_val("reset_zero", {15'd0, zero}, 16'd1);
        expect_val("reset_running", {15'd0, running}, 16'd0);
        expect_val("reset_done", {15'd0, done}, 16'd0);
        expect_val("reset_err", {15'd0, preset_err}, 16'd0);

        // Start with count 0000 in IDLE is ignored
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        expect_val("start_at_zero_running", {15'd0, running}, 16'd0);
        expect_val("start_at_zero_count", count, 16'h0000);

        // 0003 down to expiry
        drive(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        expect_val("load3_count", count, 16'h0003);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        expect_val("start3_count", count, 16'h0003);
        expect_val("start3_running", {15'd0, running}, 16'd1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        expect_val("tick3_a", count, 16'h0002);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        expect_val("tick3_b", count, 16'h0001);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        expect_val("tick3_c", count, 16'h0000);
        expect_val("expire_done", {15'd0, done}, 16'd1);
        expect_val("expire_running", {15'd0, running}, 16'd0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        expect_val("done_one_cycle", {15'd0, done}, 16'd0);
        expect_val("expired_start_ignored", {15'd0, running}, 16'd0);
        expect_val("expired_hold_zero", count, 16'h0000);

        // Borrow across three digits
        drive(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        expect_val("borrow_0999", count, 16'h0999);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        expect_val("borrow_0998", count, 16'h0998);

        // Pause wins over tick, resume continues
        drive(1'b0, 1'b1, 16'h0050, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        expect_val("pause_count", count, 16'h0050);
        expect_val("pause_running", {15'd0, running}, 16'd0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        expect_val("hold_tick_ignored", count, 16'h0050);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        expect_val("resume_no_dec", count, 16'h0050);
        expect_val("resume_running", {15'd0, running}, 16'd1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        expect_val("resume_tick", count, 16'h0049);

        // Invalid preset leaves count, sets sticky error
        drive(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 16'h12A4, 1'b0, 1'b0, 1'b0);
        expect_val("bad_load_count", count, 16'h0042);
        expect_val("bad_load_err", {15'd0, preset_err}, 16'd1);
        idle();
        expect_val("err_sticky", {15'd0, preset_err}, 16'd1);
        drive(1'b0, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);
        expect_val("good_load_err", {15'd0, preset_err}, 16'd0);
        expect_val("good_load_count", count, 16'h0007);

        // Reset overrides tick mid-count
        drive(1'b0, 1'b1, 16'h0500, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        expect_val("rst_run_count", count, 16'h0000);
        expect_val("rst_run_zero", {15'd0, zero}, 16'd1);
        expect_val("rst_run_done", {15'd0, done}, 16'd0);
        expect_val("rst_run_running", {15'd0, running}, 16'd0);
        drive(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        expect_val("rst_then_idle_start", {15'd0, running}, 16'd1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic r, l, s, pa, t;
            logic [15:0] p;
            r  = ($urandom_range(0, 99) == 0);
            l  = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 7) == 0);
            pa = ($urandom_range(0, 19) == 0);
            t  = ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 3))
                0: p = to_bcd(int'($urandom_range(0, 9999)));
                1: p = to_bcd(int'($urandom_range(0, 12)));
                2: p = 16'($urandom);
                default: p = to_bcd(int'($urandom_range(95, 105)));
            endcase
            drive(r, l, p, s, pa, t);
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
